// File: rtl/hole_fill_3x3.sv
// Streaming 3x3 binary hole filler with line history, border masking, valid/ready input and end-of-frame flush.
// Optional fill statistics are compiled in with the HF_STATS_EN macro.
module hole_fill_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sof,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_pix,
  input  logic [1:0]                          mode,
  input  logic [3:0]                          thr,
  output logic                                out_valid,
  output logic                                out_pix,
  output logic                                out_sof,
  output logic                                out_eol,
  output logic                                frame_done,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]    fill_count
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + IMG_W + 2);
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int FCW  = $clog2(NPIX + 1);
  localparam int HW   = 2 * IMG_W + 2;

  localparam logic [CW-1:0] LAST_IN_C   = CW'(NPIX - 1);
  localparam logic [CW-1:0] LAST_FL_C   = CW'(NPIX + IMG_W);
  localparam logic [CW-1:0] FIRST_OUT_C = CW'(IMG_W + 1);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
  localparam logic [XW-1:0] COL_LAST_C  = XW'(IMG_W - 1);
  localparam logic [XW-1:0] COL_ONE_C   = XW'(1);
  localparam logic [YW-1:0] ROW_LAST_C  = YW'(IMG_H - 1);
  localparam logic [YW-1:0] ROW_ONE_C   = YW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  // nbr order: {nw, n, ne, w, e, sw, s, se}
  function automatic logic fill_rule(input logic [1:0] m, input logic [3:0] t,
                                     input logic c, input logic [7:0] nbr);
    logic r;
    case (m)
      2'd0:    r = c;
      2'd1:    r = c | (nbr[6] & (nbr[4] | nbr[3]));
      2'd2:    r = c | (nbr[6] & nbr[1] & nbr[4] & nbr[3]);
      2'd3:    r = c | (popcount8(nbr) >= t);
      default: r = c;
    endcase
    return r;
  endfunction

  logic [1:0]    state_r, state_nxt_s;
  logic [CW-1:0] pix_cnt_r, j_s;
  logic [HW-1:0] hist_r;
  logic [XW-1:0] col_r;
  logic [YW-1:0] row_r;
  logic [1:0]    mode_r;
  logic [3:0]    thr_r;
  logic          in_ready_r;
  logic          acc_s, inject_s, sof_acc_s, new_pix_s, emit_s;
  logic          top_s, bot_s, lft_s, rgt_s, c_s, fill_s;
  logic [7:0]    nbr_s;
  logic          out_valid_r, out_pix_r, out_sof_r, out_eol_r, frame_done_r;

  assign acc_s = in_valid & in_ready_r;

  // Frame sequencing: decides which pixel (input or flush zero) is injected and its frame index
  always_comb begin
    state_nxt_s = state_r;
    inject_s    = 1'b0;
    sof_acc_s   = 1'b0;
    j_s         = pix_cnt_r;
    new_pix_s   = in_pix;
    case (state_r)
      S_IDLE: begin
        if (acc_s && sof) begin
          sof_acc_s   = 1'b1;
          inject_s    = 1'b1;
          j_s         = {CW{1'b0}};
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (acc_s && sof) begin
          sof_acc_s   = 1'b1;
          inject_s    = 1'b1;
          j_s         = {CW{1'b0}};
          state_nxt_s = S_RUN;
        end else if (acc_s) begin
          inject_s = 1'b1;
          if (pix_cnt_r == LAST_IN_C) begin
            state_nxt_s = S_FLUSH;
          end else begin
            state_nxt_s = S_RUN;
          end
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_FLUSH: begin
        inject_s  = 1'b1;
        new_pix_s = 1'b0;
        if (pix_cnt_r == LAST_FL_C) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_FLUSH;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  assign emit_s = inject_s & (j_s >= FIRST_OUT_C);

  // Window taps: hist_r[i] holds the pixel i+1 places behind the one being injected
  always_comb begin
    top_s = (row_r == {YW{1'b0}});
    bot_s = (row_r == ROW_LAST_C);
    lft_s = (col_r == {XW{1'b0}});
    rgt_s = (col_r == COL_LAST_C);
    c_s   = hist_r[IMG_W];
    nbr_s[7] = hist_r[2*IMG_W+1] & ~top_s & ~lft_s;
    nbr_s[6] = hist_r[2*IMG_W]   & ~top_s;
    nbr_s[5] = hist_r[2*IMG_W-1] & ~top_s & ~rgt_s;
    nbr_s[4] = hist_r[IMG_W+1]   & ~lft_s;
    nbr_s[3] = hist_r[IMG_W-1]   & ~rgt_s;
    nbr_s[2] = hist_r[1]         & ~bot_s & ~lft_s;
    nbr_s[1] = hist_r[0]         & ~bot_s;
    nbr_s[0] = new_pix_s         & ~bot_s & ~rgt_s;
    fill_s = fill_rule(mode_r, thr_r, c_s, nbr_s);
  end

  // Control state, pixel history and centre coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b1;
      pix_cnt_r  <= {CW{1'b0}};
      hist_r     <= {HW{1'b0}};
      col_r      <= {XW{1'b0}};
      row_r      <= {YW{1'b0}};
      mode_r     <= 2'd0;
      thr_r      <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != S_FLUSH);
      if (inject_s) begin
        hist_r    <= {hist_r[HW-2:0], new_pix_s};
        pix_cnt_r <= j_s + CNT_ONE_C;
      end
      if (sof_acc_s) begin
        col_r  <= {XW{1'b0}};
        row_r  <= {YW{1'b0}};
        mode_r <= mode;
        thr_r  <= thr;
      end else if (emit_s) begin
        if (rgt_s) begin
          col_r <= {XW{1'b0}};
          row_r <= bot_s ? {YW{1'b0}} : row_r + ROW_ONE_C;
        end else begin
          col_r <= col_r + COL_ONE_C;
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_pix_r    <= 1'b0;
      out_sof_r    <= 1'b0;
      out_eol_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      out_valid_r  <= emit_s;
      out_pix_r    <= emit_s & fill_s;
      out_sof_r    <= emit_s & top_s & lft_s;
      out_eol_r    <= emit_s & rgt_s;
      frame_done_r <= emit_s & bot_s & rgt_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_pix    = out_pix_r;
  assign out_sof    = out_sof_r;
  assign out_eol    = out_eol_r;
  assign frame_done = frame_done_r;

`ifdef HF_STATS_EN
  localparam logic [FCW-1:0] FC_ONE_C = FCW'(1);
  logic [FCW-1:0] stat_cnt_r;
  logic [FCW-1:0] fill_count_r;
  logic           filled_s;

  assign filled_s = fill_s & ~c_s;

  // Per-frame 0->1 counter, published once the frame's last pixel has left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt_r   <= {FCW{1'b0}};
      fill_count_r <= {FCW{1'b0}};
    end else begin
      if (emit_s) begin
        if (top_s && lft_s) begin
          stat_cnt_r <= filled_s ? FC_ONE_C : {FCW{1'b0}};
        end else if (filled_s) begin
          stat_cnt_r <= stat_cnt_r + FC_ONE_C;
        end
      end
      if (frame_done_r) begin
        fill_count_r <= stat_cnt_r;
      end
    end
  end

  assign fill_count = fill_count_r;
`else
  assign fill_count = {FCW{1'b0}};
`endif

endmodule

// File: tb/tb_hole_fill_3x3.sv
// Directed, table-driven bench for hole_fill_3x3 at IMG_W=8, IMG_H=4 (pixel p = row*8 + col).
module tb_hole_fill_3x3;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int NP  = W * H;
  localparam int FCW = $clog2(NP + 1);

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  thr;
    logic [31:0] img;
    logic [31:0] exp;
    int          fills;
  } vec_t;

  logic clk = 1'b0;
  logic rst, sof, in_valid, in_ready, in_pix;
  logic [1:0] mode;
  logic [3:0] thr;
  logic out_valid, out_pix, out_sof, out_eol, frame_done;
  logic [FCW-1:0] fill_count;

  vec_t tbl [10];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mon_idx, sof_cnt, sof_idx, done_cnt, done_idx, rdy_low, first_cyc, sof_cyc;
  logic [31:0] cap, eol_mask;

  always #5 clk = ~clk;

  hole_fill_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .mode(mode), .thr(thr), .out_valid(out_valid), .out_pix(out_pix),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done), .fill_count(fill_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!in_ready) rdy_low++;
    if (out_valid) begin
      if (mon_idx < NP) begin
        cap[mon_idx] = out_pix;
        if (out_eol) eol_mask[mon_idx] = 1'b1;
      end
      if (mon_idx == 0) first_cyc = cyc;
      if (out_sof) begin
        sof_cnt++;
        sof_idx = mon_idx;
      end
      if (frame_done) begin
        done_cnt++;
        done_idx = mon_idx;
      end
      mon_idx++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_idx = 0; cap = 32'h0; eol_mask = 32'h0; sof_cnt = 0; sof_idx = -1;
    done_cnt = 0; done_idx = -1; rdy_low = 0; first_cyc = -1; sof_cyc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic s, input logic p);
    in_valid = 1'b1; sof = s; in_pix = p;
    if (s) sof_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0; sof = 1'b0; in_pix = 1'b0;
  endtask

  task automatic gap_maybe(input bit gaps);
    for (int g = 0; g < 6 && gaps && ($urandom_range(0, 1) == 0); g++) idle(1);
  endtask

  task automatic run_frame(input int id, input bit gaps);
    clear_mon();
    mode = tbl[id].mode; thr = tbl[id].thr;
    send(1'b1, tbl[id].img[0]);
    mode = ~tbl[id].mode; thr = ~tbl[id].thr;
    for (int i = 1; i < NP; i++) begin
      gap_maybe(gaps);
      send(1'b0, tbl[id].img[i]);
    end
    for (int i = 0; i < 100 && done_cnt == 0; i++) @(negedge clk);
    idle(2);
    chk($sformatf("case%0d done_cnt", id), done_cnt, 1);
    chk($sformatf("case%0d image", id), cap, tbl[id].exp);
    chk($sformatf("case%0d out_count", id), mon_idx, NP);
    chk($sformatf("case%0d sof_cnt", id), sof_cnt, 1);
    chk($sformatf("case%0d sof_idx", id), sof_idx, 0);
    chk($sformatf("case%0d eol_mask", id), eol_mask, 32'h80808080);
    chk($sformatf("case%0d done_idx", id), done_idx, NP - 1);
    chk($sformatf("case%0d ready_low", id), rdy_low, W + 1);
    if (!gaps) chk($sformatf("case%0d latency", id), first_cyc - sof_cyc, 10);
`ifdef HF_STATS_EN
    chk($sformatf("case%0d fill_count", id), fill_count, tbl[id].fills);
`else
    chk($sformatf("case%0d fill_count", id), fill_count, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 4'd0, 32'h55555555, 32'h55555555, 0};
    tbl[1] = '{2'd1, 4'd0, 32'h00000A04, 32'h00000E04, 1};
    tbl[2] = '{2'd2, 4'd0, 32'h08140800, 32'h081C0800, 1};
    tbl[3] = '{2'd2, 4'd0, 32'h00000814, 32'h00000814, 0};
    tbl[4] = '{2'd3, 4'd8, 32'hFFFFFDFF, 32'hFFFFFFFF, 1};
    tbl[5] = '{2'd3, 4'd8, 32'hFFFFFFFE, 32'hFFFFFFFE, 0};
    tbl[6] = '{2'd3, 4'd0, 32'h00000000, 32'hFFFFFFFF, 32};
    tbl[7] = '{2'd1, 4'd0, 32'h00000081, 32'h00000081, 0};
    tbl[8] = '{2'd3, 4'd9, 32'hFFFFFDFF, 32'hFFFFFDFF, 0};
    tbl[9] = '{2'd3, 4'd3, 32'h00000302, 32'h00000303, 1};

    rst = 1'b1; sof = 1'b0; in_valid = 1'b0; in_pix = 1'b0; mode = 2'd0; thr = 4'd0;
    clear_mon();
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_pix", out_pix, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset frame_done", frame_done, 0);
    chk("reset fill_count", fill_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    for (int id = 0; id < 10; id++) run_frame(id, 1'b0);

    run_frame(1, 1'b1);
    run_frame(4, 1'b1);
    run_frame(2, 1'b1);

    // abort: 12 pixels of a frame, then a fresh sof at input index 12
    clear_mon();
    mode = 2'd0;
    send(1'b1, 1'b1);
    for (int i = 1; i < 12; i++) send(1'b0, i[0]);
    idle(1);
    chk("abort partial outputs", mon_idx, 3);
    run_frame(4, 1'b0);

    // reset in the middle of a frame
    clear_mon();
    mode = 2'd0;
    send(1'b1, 1'b1);
    for (int i = 1; i < 20; i++) send(1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_pix", out_pix, 0);
    chk("midrst out_sof", out_sof, 0);
    chk("midrst out_eol", out_eol, 0);
    chk("midrst frame_done", frame_done, 0);
    chk("midrst in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 40; i++) send(1'b0, 1'b1);
    idle(2);
    chk("no sof dropped outputs", mon_idx, 0);
    run_frame(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hole_fill_3x3.md
Name: hole_fill_3x3

Overview:
Streaming 3x3 binary hole filler for the RLE-CCA front end, placed between the binarisation stage and the run-length encoder. It owns its line buffers, column and row counters, border masking, a valid/ready input handshake and an end-of-frame flush. It generalises the single-rule window filler with a configurable image size and four runtime fill modes.

Parameters:
IMG_W, 640, pixels per line (>=4)
IMG_H, 480, lines per frame (>=3)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
sof  in  1  start of frame; qualified by in_valid&in_ready; marks pixel index 0
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts input this cycle
in_pix  in  1  binary input pixel, row-major
mode  in  2  fill rule, sampled at accepted sof
thr  in  4  neighbour threshold for mode 3, sampled at accepted sof
out_valid  out  1  output pixel valid (no backpressure)
out_pix  out  1  filled pixel
out_sof  out  1  with out_valid on output index 0
out_eol  out  1  with out_valid on column IMG_W-1
frame_done  out  1  one-cycle pulse with the last output pixel of a frame
fill_count  out  clog2(IMG_W*IMG_H+1)  pixels changed 0->1 in last frame (optional feature)

Behaviour:
- Reset: FSM=IDLE; all counters and line buffers zeroed; out_valid, out_pix, out_sof, out_eol, frame_done, fill_count = 0; in_ready = 1.
- Reset is legal mid-frame: the frame is discarded and no further outputs are produced.
- FSM states:
  - IDLE: in_ready=1; accepted pixels without sof are dropped; accepted sof -> RUN (that pixel is index 0).
  - RUN: in_ready=1; each accepted pixel advances col/row; accepting index IMG_W*IMG_H-1 -> FLUSH.
  - FLUSH: in_ready=0; injects IMG_W+1 zero pixels, one per cycle, then -> IDLE.
- Window: two internal line buffers of IMG_W bits plus a 3x3 register window. The centre is the pixel IMG_W+1 positions behind the newest injected pixel.
- Border: neighbours outside the image (row -1, row IMG_H, col -1, col IMG_W) read as 0 via row/col masking. Stale buffer contents never leak, including across a wrap from line end to line start.
- Fill rules (c = centre; N, S, E, W, NE, NW, SE, SW = neighbours):
  - mode 0: out = c (pass-through, identical timing)
  - mode 1: out = c | (N & (W | E))
  - mode 2: out = c | (N & S & W & E)
  - mode 3: out = c | (popcount(8 neighbours) >= thr); thr=0 fills everything; thr>8 never fills
- Latency: output index k is registered one cycle after accepting input index k+IMG_W+1 (or the matching flush slot). Exactly IMG_W*IMG_H outputs per frame, in order.
- out_sof / out_eol / frame_done are registered together with out_pix.
- sof accepted during RUN: the current frame is aborted with no further outputs for it; that pixel becomes index 0 of a new frame and mode/thr are resampled.
- in_valid=0 gaps stall the pipeline; out_valid stays low during stalls.
- mode/thr changes mid-frame are ignored until the next sof.

Optional Feature:
HF_STATS_EN
- Defined: a counter increments on each output where out_pix=1 and c=0. The counter clears at output index 0. fill_count is loaded with the final value in the cycle after frame_done.
- Not defined: counter is absent and fill_count is tied to 0.

Test Plan (bench overrides IMG_W=8, IMG_H=4):
- Mode 0, frame of alternating 1/0 pixels -> 32 outputs equal to input; first out_valid 10 cycles after sof; out_eol on indices 7/15/23/31; frame_done with index 31.
- Mode 1, row0 col2=1, row1 cols1,3=1, row1 col2=0 -> output index 10 = 1; all other pixels unchanged.
- Mode 2, single 0 at (2,3) with its 4 neighbours=1 -> filled. Same pattern at (0,3) (N is border) -> stays 0.
- Mode 3 thr=8, all-ones frame except (1,1)=0 -> (1,1) filled. Same with (0,0)=0 -> not filled (border neighbours are 0). With HF_STATS_EN: fill_count=1 for the first case, 0 for the second.
- Random in_valid gaps at 50% -> output sequence identical to gap-free run; in_ready low for exactly 9 cycles during FLUSH.
- sof reasserted at input index 12, then a full frame -> outputs of the aborted frame stop; new frame yields exactly 32 outputs with out_sof once. rst pulsed mid-frame -> all outputs 0 and in_ready=1 next cycle.
